// File: rtl/bpu_update_queue.sv
// In-order queue of resolved conditional-branch outcomes feeding the BPU training
// port, with saturating branch / mispredict counters for performance debug.
module bpu_update_queue #(
  parameter int DEPTH_LOG2 = 2,
  parameter int STAT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_addr,
  input  logic                  in_taken,
  input  logic                  in_pred_valid,
  input  logic                  in_pred_taken,
  input  logic                  drain_en,
  output logic                  update_valid,
  output logic [31:0]           update_addr,
  output logic                  update_taken,
  output logic [DEPTH_LOG2:0]   occupancy,
  input  logic                  stat_clear,
  output logic [STAT_W-1:0]     stat_branches,
  output logic [STAT_W-1:0]     stat_mispredicts
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   OCC_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   OCC_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [STAT_W-1:0]     STAT_ONE = 1;

  logic [31:0]           addr_mem  [DEPTH];
  logic                  taken_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  occ_nz;
  logic                  push;
  logic                  pop;
  logic                  mispredict;

  // Handshakes: a transfer happens on a clock edge where valid && ready.
  // in_ready is computed from occupancy alone (a full queue never accepts,
  // even while draining); the BPU side has no ready beyond drain_en.
  assign occ_nz       = (occupancy != '0);
  assign in_ready     = (occupancy != OCC_FULL);
  assign push         = in_valid && in_ready;
  assign update_valid = occ_nz && drain_en;
  assign pop          = update_valid;

  // Empty queue drives zeros so stale or uninitialised storage never leaks out.
  assign update_addr  = occ_nz ? addr_mem[rd_ptr]  : 32'h0;
  assign update_taken = occ_nz ? taken_mem[rd_ptr] : 1'b0;

  assign mispredict = in_pred_valid && (in_pred_taken != in_taken);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr]  <= in_addr;
      taken_mem[wr_ptr] <= in_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Clear wins over a same-cycle push; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clear) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (push) begin
      if (stat_branches != '1)
        stat_branches <= stat_branches + STAT_ONE;
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + STAT_ONE;
    end
  end

endmodule

// File: tb/tb_bpu_update_queue.sv
// Directed bench for bpu_update_queue: latency, full/wrap, concurrent push/pop,
// statistics with clear and saturation (STAT_W=4), and asynchronous reset.
module tb_bpu_update_queue;

  localparam int DL = 2;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_addr = '0;
  logic          in_taken = 1'b0;
  logic          in_pred_valid = 1'b0;
  logic          in_pred_taken = 1'b0;
  logic          drain_en = 1'b0;
  logic          update_valid;
  logic [31:0]   update_addr;
  logic          update_taken;
  logic [DL:0]   occupancy;
  logic          stat_clear = 1'b0;
  logic [SW-1:0] stat_branches;
  logic [SW-1:0] stat_mispredicts;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int p0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  bpu_update_queue #(.DEPTH_LOG2(DL), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_taken(in_taken),
    .in_pred_valid(in_pred_valid), .in_pred_taken(in_pred_taken),
    .drain_en(drain_en),
    .update_valid(update_valid), .update_addr(update_addr), .update_taken(update_taken),
    .occupancy(occupancy), .stat_clear(stat_clear),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every emitted update must match the oldest accepted entry
  always @(negedge clk) begin
    if (!rst && update_valid === 1'b1) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk("spurious_update_qsize", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("upd_addr", update_addr, mon_e[32:1]);
        chk("upd_taken", 32'(update_taken), 32'(mon_e[0]));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic t, input logic pv, input logic pt);
    in_valid      = 1'b1;
    in_addr       = a;
    in_taken      = t;
    in_pred_valid = pv;
    in_pred_taken = pt;
  endtask

  task automatic push1(input logic [31:0] a, input logic t, input logic pv, input logic pt);
    drive(a, t, pv, pt);
    @(negedge clk);
    chk("push_ready", 32'(in_ready), 32'd1);
    if (in_ready) exp_q.push_back({a, t});
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (occupancy == '0) break;
    end
    chk("drained_occ", 32'(occupancy), 32'd0);
    step();
  endtask

  initial begin
    // reset state, sampled while rst is held
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_valid", 32'(update_valid), 32'd0);
    chk("rst_addr", update_addr, 32'd0);
    chk("rst_taken", 32'(update_taken), 32'd0);
    chk("rst_branches", 32'(stat_branches), 32'd0);
    chk("rst_mispred", 32'(stat_mispredicts), 32'd0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_valid", 32'(update_valid), 32'd0);
    step();

    // single push: visible one cycle after acceptance, no bypass
    drain_en = 1'b1;
    drive(32'h0000_1004, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_no_bypass", 32'(update_valid), 32'd0);
    chk("lat_ready", 32'(in_ready), 32'd1);
    exp_q.push_back({32'h0000_1004, 1'b1});
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("single_valid", 32'(update_valid), 32'd1);
    chk("single_addr", update_addr, 32'h0000_1004);
    chk("single_taken", 32'(update_taken), 32'd1);
    chk("single_occ", 32'(occupancy), 32'd1);
    step();
    @(negedge clk);
    chk("single_occ_after", 32'(occupancy), 32'd0);
    chk("single_valid_after", 32'(update_valid), 32'd0);
    step();

    // fill to full, hold 5th, drain with wrap
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push1(32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    drive(32'h110, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd4);
    step();
    @(negedge clk);
    chk("held_ready", 32'(in_ready), 32'd0);
    chk("held_valid", 32'(update_valid), 32'd0);
    chk("held_occ", 32'(occupancy), 32'd4);
    step();
    drain_en = 1'b1;
    @(negedge clk);
    chk("drain_first_valid", 32'(update_valid), 32'd1);
    chk("full_ready_while_drain", 32'(in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("ready_after_pop", 32'(in_ready), 32'd1);
    chk("occ_after_pop", 32'(occupancy), 32'd3);
    if (in_ready) exp_q.push_back({32'h110, 1'b1});
    step();
    in_valid = 1'b0;
    wait_empty();
    chk("fill_q_empty", 32'(exp_q.size()), 32'd0);

    // concurrent push/pop at occupancy 2
    drain_en = 1'b0;
    push1(32'h200, 1'b0, 1'b0, 1'b0);
    push1(32'h204, 1'b1, 1'b0, 1'b0);
    drain_en = 1'b1;
    p0 = pops;
    for (int k = 0; k < 10; k++) begin
      drive(32'h208 + 32'(4 * k), k[0], 1'b0, 1'b0);
      @(negedge clk);
      chk("sim_occ", 32'(occupancy), 32'd2);
      chk("sim_ready", 32'(in_ready), 32'd1);
      if (in_ready) exp_q.push_back({32'h208 + 32'(4 * k), k[0]});
      step();
    end
    in_valid = 1'b0;
    chk("sim_pops", 32'(pops - p0), 32'd10);
    wait_empty();
    // 18 unpredicted pushes so far on a 4-bit counter
    chk("sat_pre_branches", 32'(stat_branches), 32'd15);
    chk("sat_pre_mispred", 32'(stat_mispredicts), 32'd0);

    // statistics
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    @(negedge clk);
    chk("clr_branches", 32'(stat_branches), 32'd0);
    chk("clr_mispred", 32'(stat_mispredicts), 32'd0);
    step();
    push1(32'h300, 1'b0, 1'b1, 1'b1);
    push1(32'h304, 1'b0, 1'b1, 1'b0);
    push1(32'h308, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("stat_branches", 32'(stat_branches), 32'd3);
    chk("stat_mispred", 32'(stat_mispredicts), 32'd1);
    step();
    stat_clear = 1'b1;
    push1(32'h30C, 1'b0, 1'b1, 1'b1);
    stat_clear = 1'b0;
    @(negedge clk);
    chk("clr_push_branches", 32'(stat_branches), 32'd0);
    chk("clr_push_mispred", 32'(stat_mispredicts), 32'd0);
    step();
    wait_empty();

    // saturation
    for (int i = 0; i < 14; i++) push1(32'h400 + 32'(4 * i), 1'b0, 1'b1, 1'b1);
    chk("sat14_branches", 32'(stat_branches), 32'd14);
    chk("sat14_mispred", 32'(stat_mispredicts), 32'd14);
    for (int i = 14; i < 17; i++) push1(32'h400 + 32'(4 * i), 1'b0, 1'b1, 1'b1);
    chk("sat_branches", 32'(stat_branches), 32'd15);
    chk("sat_mispred", 32'(stat_mispredicts), 32'd15);
    wait_empty();

    // asynchronous reset with three entries queued
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) push1(32'h600 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("prerst_occ", 32'(occupancy), 32'd3);
    step();
    drain_en = 1'b1;
    #1;
    chk("prerst_valid", 32'(update_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(update_valid), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_addr", update_addr, 32'd0);
    exp_q.delete();
    #3;
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(update_valid), 32'd0);
      step();
    end
    chk("post_rst_branches", 32'(stat_branches), 32'd0);
    push1(32'h700, 1'b1, 1'b0, 1'b0);
    wait_empty();
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
